tof_bram_read_arb: RTL and testbench

TOF_BRAM_READ_ARB -- requirements
Module: tof_bram_read_arb

---
 rtl/tof_bram_read_arb.sv | 127 ++++++++++++
 tb/tb_tof_bram_read_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tof_bram_read_arb.sv
// Round-robin arbiter giving two requesters burst read access to the ToF BRAM port B.
// A grant latches address/length; the burst streams one address per cycle, then drains the read pipeline.
module tof_bram_read_arb #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid0,
  output logic              rd_valid1,
  output logic              rd_last,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;          // 1: requester 1 was granted last
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              issue_q, issue_d;
  logic              issue_last_q, issue_last_d;
  logic [ADDR_W-1:0] bram_addr_d;
  logic              gnt0_d, gnt1_d;
  logic              rd_valid0_d, rd_valid1_d, rd_last_d, busy_d;
  logic              pick1;
  logic [LEN_W-1:0]  pick_len;

  assign rd_data = bram_dout;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    issue_d      = 1'b0;
    issue_last_d = 1'b0;
    bram_addr_d  = bram_addr;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rd_valid0_d  = issue_q & ~owner_q;
    rd_valid1_d  = issue_q & owner_q;
    rd_last_d    = issue_last_q;
    pick1        = req1 & (~req0 | ~rr_q);
    pick_len     = pick1 ? len1 : len0;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          owner_d = pick1;
          rr_d    = pick1;
          cur_d   = pick1 ? addr1 : addr0;
          cnt_d   = pick_len;
          if (pick_len != LEN_W'(0)) state_d = BURST;
        end
      end
      BURST: begin
        if (cnt_q != LEN_W'(0)) begin
          bram_addr_d  = cur_q;
          cur_d        = cur_q + ADDR_W'(1);
          cnt_d        = cnt_q - LEN_W'(1);
          issue_d      = 1'b1;
          issue_last_d = (cnt_q == LEN_W'(1));
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      rr_q         <= 1'b1;
      cur_q        <= '0;
      cnt_q        <= '0;
      issue_q      <= 1'b0;
      issue_last_q <= 1'b0;
      bram_addr    <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rd_valid0    <= 1'b0;
      rd_valid1    <= 1'b0;
      rd_last      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      issue_q      <= issue_d;
      issue_last_q <= issue_last_d;
      bram_addr    <= bram_addr_d;
      gnt0         <= gnt0_d;
      gnt1         <= gnt1_d;
      rd_valid0    <= rd_valid0_d;
      rd_valid1    <= rd_valid1_d;
      rd_last      <= rd_last_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_tof_bram_read_arb.sv
// Directed bench for tof_bram_read_arb: a timeline model predicts every output per cycle,
// plus hand-computed literal checks for the key scenarios.
module tb_tof_bram_read_arb;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 7;
  localparam int N = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [LEN_W-1:0]  len0, len1;
  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid0, rd_valid1, rd_last, busy;

  tof_bram_read_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .rd_data(rd_data), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
    .rd_last(rd_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // BRAM with one-cycle read latency
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i * 37 + 5);
  always @(posedge clk) bram_dout <= mem[bram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Timeline model: each grant schedules its whole burst into per-cycle expectation arrays
  int                exp_gnt [N];   // 0 none, 1 requester0, 2 requester1
  int                exp_val [N];   // same encoding for rd_valid
  bit                exp_last[N];
  bit                exp_busy[N];
  bit                addr_set[N];
  logic [ADDR_W-1:0] exp_addr[N];
  logic [ADDR_W-1:0] cur_exp_addr = '0;
  logic [ADDR_W-1:0] prev_exp_addr = '0;
  bit armed = 0;
  int free_at = 0;
  int last_w = 1;

  always @(negedge clk) begin
    int c, w, l, a;
    c = cyc;
    if (armed) begin
      if (addr_set[c]) cur_exp_addr = exp_addr[c];
      chk("gnt0", 32'(gnt0), 32'(exp_gnt[c] == 1));
      chk("gnt1", 32'(gnt1), 32'(exp_gnt[c] == 2));
      chk("rd_valid0", 32'(rd_valid0), 32'(exp_val[c] == 1));
      chk("rd_valid1", 32'(rd_valid1), 32'(exp_val[c] == 2));
      chk("rd_last", 32'(rd_last), 32'(exp_last[c]));
      chk("busy", 32'(busy), 32'(exp_busy[c]));
      chk("bram_addr", 32'(bram_addr), 32'(cur_exp_addr));
      if (exp_val[c] != 0) chk("rd_data", 32'(rd_data), 32'(mem[prev_exp_addr]));
      prev_exp_addr = cur_exp_addr;
    end
    if (reset) begin
      for (int i = c + 1; i < N; i++) begin
        exp_gnt[i] = 0; exp_val[i] = 0; exp_last[i] = 0; exp_busy[i] = 0; addr_set[i] = 0;
      end
      if (c + 1 < N) begin addr_set[c+1] = 1; exp_addr[c+1] = '0; end
      free_at = c + 1;
      last_w  = 1;
      armed   = 1;
    end else if (armed && c >= free_at && (req0 || req1)) begin
      w = (req0 && (!req1 || last_w == 1)) ? 0 : 1;
      a = (w == 1) ? int'(addr1) : int'(addr0);
      l = (w == 1) ? int'(len1) : int'(len0);
      if (c + l + 3 < N) begin
        exp_gnt[c+1] = w + 1;
        for (int k = 0; k < l; k++) begin
          addr_set[c+2+k] = 1;
          exp_addr[c+2+k] = ADDR_W'(a + k);
          exp_val[c+3+k]  = w + 1;
        end
        if (l > 0) begin
          exp_last[c+2+l] = 1;
          for (int b = c + 1; b <= c + 2 + l; b++) exp_busy[b] = 1;
        end
      end
      free_at = (l > 0) ? c + 3 + l : c + 1;
      last_w  = w;
    end
  end

  // Requesters drop their request in the grant cycle unless told to hold it
  bit hold0 = 0, hold1 = 0;
  task automatic tick();
    @(posedge clk); #1;
    if (gnt0 && !hold0) req0 = 1'b0;
    if (gnt1 && !hold1) req1 = 1'b0;
  endtask

  task automatic wait_gnt(input int which, output int tg);
    tg = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ((which == 0 && gnt0) || (which == 1 && gnt1)) begin
        tg = cyc;
        return;
      end
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  initial begin
    int t, t0, t1;
    int g_cyc [4];
    int g_who [4];
    int ng;
    reset = 1'b1; req0 = 0; req1 = 0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_addr", 32'(bram_addr), 32'd0);
    tick();

    // Single len=4 burst from requester 0
    addr0 = 9'h040; len0 = 7'd4; req0 = 1'b1;
    wait_gnt(0, t);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 4) chk("lit_addr", 32'(bram_addr), 32'h040 + 32'(k - 1));
      chk("lit_rv0", 32'(rd_valid0), 32'(k >= 2 && k <= 5));
      chk("lit_last", 32'(rd_last), 32'(k == 5));
      chk("lit_busy", 32'(busy), 32'(k <= 5));
    end

    // Both requesters held high: alternation with 5-cycle spacing
    pulse_reset();
    addr0 = 9'h010; len0 = 7'd2; addr1 = 9'h0A0; len1 = 7'd2;
    hold0 = 1; hold1 = 1; req0 = 1; req1 = 1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      tick();
      if (gnt0 || gnt1) begin g_cyc[ng] = cyc; g_who[ng] = gnt1 ? 1 : 0; ng++; end
    end
    req0 = 0; req1 = 0; hold0 = 0; hold1 = 0;
    chk("rr_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4 && i < ng; i++) begin
      chk("rr_who", 32'(g_who[i]), 32'(i % 2));
      if (i > 0) chk("rr_space", 32'(g_cyc[i] - g_cyc[i-1]), 32'd5);
    end
    repeat (6) tick();

    // Address wrap on requester 1
    addr1 = 9'h1FE; len1 = 7'd4; req1 = 1'b1;
    wait_gnt(1, t);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("wrap_addr", 32'(bram_addr), 32'(ADDR_W'(32'h1FE + 32'(k - 1))));
    end
    repeat (4) tick();

    // Zero-length grant, then waiting requester 1 granted next cycle
    pulse_reset();
    addr0 = 9'h033; len0 = 7'd0; addr1 = 9'h150; len1 = 7'd2;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(0, t0);
    chk("len0_busy", 32'(busy), 32'd0);
    tick();
    chk("len0_next_gnt1", 32'(gnt1), 32'd1);
    repeat (6) tick();

    // Reset on the third BURST cycle of a long burst; request held across reset
    addr0 = 9'h080; len0 = 7'd64; req0 = 1'b1;
    wait_gnt(0, t);
    tick(); tick();
    reset = 1'b1; addr1 = 9'h010; len1 = 7'd3; req1 = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rv0", 32'(rd_valid0), 32'd0);
    chk("abort_last", 32'(rd_last), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(bram_addr), 32'd0);
    wait_gnt(1, t1);
    chk("post_reset_gnt", 32'(t1 - t), 32'd4);
    repeat (8) tick();

    // Inputs changed mid-burst do not disturb it; req1 waits until after DRAIN
    addr0 = 9'h100; len0 = 7'd5; req0 = 1'b1;
    wait_gnt(0, t0);
    addr0 = 9'h1AA; len0 = 7'd9; addr1 = 9'h020; len1 = 7'd2; req1 = 1'b1;
    wait_gnt(1, t1);
    chk("mid_gnt1_gap", 32'(t1 - t0), 32'd8);
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
